alu_result_buffer: RTL and testbench

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_result_buffer_sat_counter.sv | 36 +++
 rtl/alu_result_buffer.sv | 114 +++++++++++
 tb/tb_alu_result_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: result word width, opcode encoding and buffer status limits.
// Consumed by the ALU and by the result buffer that sits behind it.
package alu_pkg;

    localparam int RESULT_W   = 6;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_t;

    // True for opcodes that produce a result word on the ALU out port.
    function automatic logic op_has_result(input op_t op);
        return op != OP_NOP;
    endfunction

endpackage : alu_pkg

// File: rtl/alu_result_buffer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
// Used by the result buffer to count dropped ALU results.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/alu_result_buffer.sv
// First-word-fall-through result FIFO behind the ALU. Never backpressures the ALU:
// results arriving while full (and not draining) are dropped and counted.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = RESULT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         res_in,
    input  logic                     res_valid_in,
    input  logic                     clear_in,
    output logic [WIDTH-1:0]         res_out,
    output logic                     res_valid_out,
    input  logic                     res_ready_in,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_out,
    output logic [DROP_CNT_W-1:0]    drop_cnt_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Clear outranks everything: a push in the same cycle is neither stored nor counted as a drop.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CW'(DEPTH));
        pop   = !empty && res_ready_in;
        push  = res_valid_in && (!full || pop) && !clear_in;
        drop  = res_valid_in && full && !pop && !clear_in;
    end

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (clear_in) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= res_in;
        end
    end

    sat_counter #(
        .WIDTH (DROP_CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (drop),
        .clr_i (clear_in),
        .cnt_o (drop_cnt_out)
    );

    // Masking the head with empty keeps res_out at zero through reset despite unreset storage.
    assign res_out       = empty ? '0 : mem[rd_ptr_q];
    assign res_valid_out = !empty;
    assign count_out     = count_q;
    assign overflow_out  = overflow_q;

endmodule : alu_result_buffer

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed vector table, corner-case
// sequences and randomized traffic checked against a queue-based reference model.
module tb_alu_result_buffer;

    localparam int DEPTH = 8;
    localparam int W     = 6;

    logic         clk;
    logic         rst;
    logic [W-1:0] res_in;
    logic         res_valid_in;
    logic         clear_in;
    logic [W-1:0] res_out;
    logic         res_valid_out;
    logic         res_ready_in;
    logic [3:0]   count_out;
    logic         overflow_out;
    logic [7:0]   drop_cnt_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain queue of stored words plus status.
    int unsigned m_q[$];
    bit          m_ovf;
    int          m_drops;

    alu_result_buffer #(.DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .res_in        (res_in),
        .res_valid_in  (res_valid_in),
        .clear_in      (clear_in),
        .res_out       (res_out),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .count_out     (count_out),
        .overflow_out  (overflow_out),
        .drop_cnt_out  (drop_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit v, input int unsigned d, input bit r, input bit c);
        bit popped;
        if (c) begin
            model_reset();
            return;
        end
        popped = (m_q.size() > 0) && r;
        if (popped) void'(m_q.pop_front());
        if (v) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(d);
            end else begin
                m_ovf   = 1'b1;
                m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        int exp_head;
        exp_head = (m_q.size() > 0) ? int'(m_q[0]) : 0;
        check({tag, ".count"}, int'(count_out), m_q.size());
        check({tag, ".valid"}, int'(res_valid_out), (m_q.size() != 0) ? 1 : 0);
        check({tag, ".res"}, int'(res_out), exp_head);
        check({tag, ".ovf"}, int'(overflow_out), int'(m_ovf));
        check({tag, ".drops"}, int'(drop_cnt_out), m_drops);
    endtask

    // Drive inputs, update the model, then advance past the next rising edge.
    task automatic tick(input bit v, input int unsigned d, input bit r, input bit c);
        res_valid_in = v;
        res_in       = W'(d);
        res_ready_in = r;
        clear_in     = c;
        model_step(v, d, r, c);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          v;
        int unsigned d;
        bit          r;
        bit          c;
        int          e_count;
        int          e_valid;
        int          e_res;
        int          e_ovf;
        int          e_drops;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst          = 1'b1;
        res_in       = '0;
        res_valid_in = 1'b0;
        res_ready_in = 1'b0;
        clear_in     = 1'b0;
        model_reset();

        #1;
        check("reset.count", int'(count_out), 0);
        check("reset.valid", int'(res_valid_out), 0);
        check("reset.res", int'(res_out), 0);
        check("reset.ovf", int'(overflow_out), 0);
        check("reset.drops", int'(drop_cnt_out), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_model("post_reset");

        // Directed table: single transfer with hold, ignored ready when empty, FWFT, push+pop, clear.
        vecs.push_back('{1, 'h2A, 0, 0, 1, 1, 'h2A, 0, 0});
        vecs.push_back('{0, 'h00, 0, 0, 1, 1, 'h2A, 0, 0});
        vecs.push_back('{0, 'h11, 0, 0, 1, 1, 'h2A, 0, 0});
        vecs.push_back('{0, 'h00, 1, 0, 0, 0, 'h00, 0, 0});
        vecs.push_back('{0, 'h00, 1, 0, 0, 0, 'h00, 0, 0});
        vecs.push_back('{1, 'h05, 1, 0, 1, 1, 'h05, 0, 0});
        vecs.push_back('{1, 'h06, 0, 0, 2, 1, 'h05, 0, 0});
        vecs.push_back('{1, 'h07, 1, 0, 2, 1, 'h06, 0, 0});
        vecs.push_back('{1, 'h09, 1, 1, 0, 0, 'h00, 0, 0});
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c);
            check($sformatf("vec%0d.count", i), int'(count_out), vecs[i].e_count);
            check($sformatf("vec%0d.valid", i), int'(res_valid_out), vecs[i].e_valid);
            check($sformatf("vec%0d.res", i), int'(res_out), vecs[i].e_res);
            check($sformatf("vec%0d.ovf", i), int'(overflow_out), vecs[i].e_ovf);
            check($sformatf("vec%0d.drops", i), int'(drop_cnt_out), vecs[i].e_drops);
        end

        // Fill 1..8, overflow with 3 more, then drain and confirm original contents.
        for (int i = 1; i <= 8; i++) tick(1, i, 0, 0);
        check("fill.count", int'(count_out), 8);
        for (int i = 0; i < 3; i++) tick(1, 'h30 + i, 0, 0);
        check("ovf.drops", int'(drop_cnt_out), 3);
        check("ovf.flag", int'(overflow_out), 1);
        check("ovf.count", int'(count_out), 8);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain%0d.res", i), int'(res_out), i);
            tick(0, 0, 1, 0);
        end
        check("drain.count", int'(count_out), 0);
        check("drain.valid", int'(res_valid_out), 0);
        check_model("drain");

        // Full with simultaneous push and pop: no drop, 0x3F becomes the last word.
        tick(0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) tick(1, i, 0, 0);
        tick(1, 'h3F, 1, 0);
        check("fullpp.count", int'(count_out), 8);
        check("fullpp.drops", int'(drop_cnt_out), 0);
        check("fullpp.ovf", int'(overflow_out), 0);
        for (int i = 2; i <= 8; i++) begin
            check($sformatf("fullpp_out%0d", i), int'(res_out), i);
            tick(0, 0, 1, 0);
        end
        check("fullpp.last", int'(res_out), 'h3F);
        tick(0, 0, 1, 0);
        check_model("fullpp_end");

        // Saturation: 300 drops, then clear with a concurrent push and pop.
        for (int i = 1; i <= 8; i++) tick(1, i, 0, 0);
        for (int i = 0; i < 300; i++) begin
            tick(1, $urandom_range(0, 63), 0, 0);
            if (i == 253) check("sat.254", int'(drop_cnt_out), 254);
        end
        check("sat.255", int'(drop_cnt_out), 255);
        check("sat.ovf", int'(overflow_out), 1);
        check_model("sat");
        tick(1, 'h15, 1, 1);
        check("clr.count", int'(count_out), 0);
        check("clr.ovf", int'(overflow_out), 0);
        check("clr.drops", int'(drop_cnt_out), 0);
        check("clr.valid", int'(res_valid_out), 0);

        // Asynchronous reset between edges with 5 words stored.
        for (int i = 0; i < 5; i++) tick(1, 'h20 + i, 0, 0);
        check("pre_arst.count", int'(count_out), 5);
        #3;
        rst = 1'b1;
        #1;
        check("arst.valid", int'(res_valid_out), 0);
        check("arst.count", int'(count_out), 0);
        check("arst.res", int'(res_out), 0);
        model_reset();
        @(posedge clk);
        #1;
        check_model("arst_hold");
        rst = 1'b0;
        tick(1, 'h11, 0, 0);
        check_model("after_arst");

        // Randomized traffic; ready bias alternates so the buffer spends time both full and empty.
        for (int i = 0; i < 600; i++) begin
            bit v, r, c;
            v = ($urandom_range(0, 3) != 0);
            r = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 79) == 0);
            tick(v, $urandom_range(0, 63), r, c);
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_result_buffer
